// File: rtl/branch_ctrl_if.sv
// Request bus between the execute-stage issue logic and the branch sequencer.
//   req_valid   issuer has a branch/jump request
//   req_ready   sequencer can take it (only while idle)
//   req_func    funct3 of the branch
//   req_is_jal  / req_is_jalr   jump flavour
//   req_pc, req_rs1, req_rs2, req_imm   operands (imm already sign-extended)
interface branch_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_func;
    logic             req_is_jal;
    logic             req_is_jalr;
    logic [WIDTH-1:0] req_pc;
    logic [WIDTH-1:0] req_rs1;
    logic [WIDTH-1:0] req_rs2;
    logic [WIDTH-1:0] req_imm;

    modport master (
        output req_valid, req_func, req_is_jal, req_is_jalr,
               req_pc, req_rs1, req_rs2, req_imm,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_func, req_is_jal, req_is_jalr,
               req_pc, req_rs1, req_rs2, req_imm,
        output req_ready
    );
endinterface

// File: rtl/branch_ctrl.sv
// Multicycle branch/jump sequencer for the execute stage.
// A request is captured in IDLE, resolved in a single EVAL cycle, and then
// either retires not-taken, redirects fetch (REDIR) or raises a trap (TRAP).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req                      request bus (branch_ctrl_if.slave)
//   redirect_valid/ready/pc  PC redirect handshake towards fetch
//   flush                    pulse on redirect handshake
//   link_we, link_data       rd write of pc+4 for JAL/JALR
//   done                     pulse when the instruction leaves the unit
//   exc_valid/cause/tval/ack trap request handshake
//   taken_cnt, total_cnt     saturating statistics counters
module branch_ctrl #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16,
    parameter int C_EXT     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_ctrl_if.slave         req,
    output logic                 redirect_valid,
    input  logic                 redirect_ready,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic                 flush,
    output logic                 link_we,
    output logic [WIDTH-1:0]     link_data,
    output logic                 done,
    output logic                 exc_valid,
    output logic [3:0]           exc_cause,
    output logic [WIDTH-1:0]     exc_tval,
    input  logic                 exc_ack,
    output logic [CNT_WIDTH-1:0] taken_cnt,
    output logic [CNT_WIDTH-1:0] total_cnt
);
    typedef enum logic [1:0] {IDLE, EVAL, REDIR, TRAP} state_t;

    state_t state, nxt;

    logic [2:0]       r_func;
    logic             r_jal;
    logic             r_jalr;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_rs1;
    logic [WIDTH-1:0] r_rs2;
    logic [WIDTH-1:0] r_imm;

    logic             be_branch;
    logic             be_exc;
    logic             ev_illegal;
    logic             ev_taken;
    logic             ev_misal;
    logic [WIDTH-1:0] ev_target;

    branch_eval #(.WIDTH(WIDTH)) u_eval (
        .func      (r_func),
        .a         (r_rs1),
        .b         (r_rs2),
        .branch    (be_branch),
        .exception (be_exc)
    );

    // Outcome of the registered request; only consumed in EVAL.
    always_comb begin
        ev_illegal = 1'b0;
        ev_taken   = 1'b0;
        ev_target  = r_pc + r_imm;
        if (r_jal && r_jalr) begin
            ev_illegal = 1'b1;
        end else if (r_jal) begin
            ev_taken = 1'b1;
        end else if (r_jalr) begin
            ev_taken  = 1'b1;
            ev_target = (r_rs1 + r_imm) & ~WIDTH'(1);
        end else if (be_exc) begin
            ev_illegal = 1'b1;
        end else begin
            ev_taken = be_branch;
        end
        // Alignment only matters for a target we would actually jump to.
        if (C_EXT != 0) ev_misal = ev_taken && ev_target[0];
        else            ev_misal = ev_taken && (ev_target[1:0] != 2'b00);
    end

    always_comb begin
        nxt            = state;
        req.req_ready  = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        link_we        = 1'b0;
        done           = 1'b0;
        exc_valid      = 1'b0;
        case (state)
            IDLE: begin
                req.req_ready = 1'b1;
                if (req.req_valid) nxt = EVAL;
            end
            EVAL: begin
                if (ev_illegal || ev_misal) begin
                    nxt = TRAP;
                end else if (ev_taken) begin
                    nxt = REDIR;
                end else begin
                    done = 1'b1;
                    nxt  = IDLE;
                end
            end
            REDIR: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    flush   = 1'b1;
                    done    = 1'b1;
                    link_we = r_jal | r_jalr;
                    nxt     = IDLE;
                end
            end
            TRAP: begin
                exc_valid = 1'b1;
                if (exc_ack) begin
                    done = 1'b1;
                    nxt  = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            r_func      <= '0;
            r_jal       <= 1'b0;
            r_jalr      <= 1'b0;
            r_pc        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_imm       <= '0;
            redirect_pc <= '0;
            link_data   <= '0;
            exc_cause   <= '0;
            exc_tval    <= '0;
            taken_cnt   <= '0;
            total_cnt   <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && req.req_valid) begin
                r_func    <= req.req_func;
                r_jal     <= req.req_is_jal;
                r_jalr    <= req.req_is_jalr;
                r_pc      <= req.req_pc;
                r_rs1     <= req.req_rs1;
                r_rs2     <= req.req_rs2;
                r_imm     <= req.req_imm;
                link_data <= req.req_pc + WIDTH'(4);
            end
            if (state == EVAL) begin
                if (ev_illegal) begin
                    exc_cause <= 4'd2;
                    exc_tval  <= '0;
                end else if (ev_misal) begin
                    exc_cause <= 4'd0;
                    exc_tval  <= ev_target;
                end else if (ev_taken) begin
                    redirect_pc <= ev_target;
                end
            end
            if (done && total_cnt != '1) total_cnt <= total_cnt + CNT_WIDTH'(1);
            if (flush && taken_cnt != '1) taken_cnt <= taken_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// RV32I conditional branch comparator. funct3 010/011 are not branches.
module branch_eval #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             branch,
    output logic             exception
);
    always_comb begin
        branch    = 1'b0;
        exception = 1'b0;
        case (func)
            3'b000:  branch = (a == b);
            3'b001:  branch = (a != b);
            3'b100:  branch = ($signed(a) <  $signed(b));
            3'b101:  branch = ($signed(a) >= $signed(b));
            3'b110:  branch = (a <  b);
            3'b111:  branch = (a >= b);
            default: exception = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
    localparam int W  = 32;
    localparam int CW = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          redirect_valid, redirect_ready, flush, link_we, done;
    logic          exc_valid, exc_ack;
    logic [W-1:0]  redirect_pc, link_data, exc_tval;
    logic [3:0]    exc_cause;
    logic [CW-1:0] taken_cnt, total_cnt;

    always #5 clk = ~clk;

    branch_ctrl_if #(.WIDTH(W)) req_if ();

    branch_ctrl #(.WIDTH(W), .CNT_WIDTH(CW), .C_EXT(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req_if),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .link_we        (link_we),
        .link_data      (link_data),
        .done           (done),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_tval       (exc_tval),
        .exc_ack        (exc_ack),
        .taken_cnt      (taken_cnt),
        .total_cnt      (total_cnt)
    );

    // kind: 0 retire not-taken, 1 redirect, 2 trap
    typedef struct {
        int unsigned kind;
        logic [31:0] pc;
        bit          lwe;
        logic [31:0] ldata;
        logic [3:0]  cause;
        logic [31:0] tval;
        int unsigned acc;
    } exp_t;

    exp_t        q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned hold = 0;
    int unsigned m_taken = 0;
    int unsigned m_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Architectural outcome straight from the RV32I branch/jump rules.
    function automatic exp_t model(input logic [2:0] f, input bit jal, input bit jalr,
                                   input logic [31:0] pc, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm);
        exp_t e;
        bit illegal = 0;
        bit taken = 0;
        logic [31:0] t = pc + imm;
        e = '{kind: 0, pc: 0, lwe: 0, ldata: pc + 32'd4, cause: 0, tval: 0, acc: 0};
        if (jal && jalr) illegal = 1;
        else if (jal) taken = 1;
        else if (jalr) begin
            taken = 1;
            t = (rs1 + imm) & 32'hFFFF_FFFE;
        end else begin
            case (f)
                3'd0: taken = (rs1 == rs2);
                3'd1: taken = (rs1 != rs2);
                3'd4: taken = (int'(rs1) < int'(rs2));
                3'd5: taken = (int'(rs1) >= int'(rs2));
                3'd6: taken = (rs1 < rs2);
                3'd7: taken = (rs1 >= rs2);
                default: illegal = 1;
            endcase
        end
        if (illegal) begin
            e.kind = 2; e.cause = 4'd2; e.tval = 0;
        end else if (taken && (t % 4 != 0)) begin
            e.kind = 2; e.cause = 4'd0; e.tval = t;
        end else if (taken) begin
            e.kind = 1; e.pc = t; e.lwe = jal || jalr;
        end
        return e;
    endfunction

    // Fetch / trap-unit responder: withholds ready/ack for `hold` cycles.
    initial begin
        int unsigned wc = 0;
        redirect_ready = 1'b0;
        exc_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && (redirect_valid || exc_valid)) begin
                redirect_ready = redirect_valid && (wc >= hold);
                exc_ack        = exc_valid && (wc >= hold);
                wc++;
            end else begin
                redirect_ready = 1'b0;
                exc_ack = 1'b0;
                wc = 0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            int unsigned obs;
            check("taken_cnt", 32'(taken_cnt), m_taken);
            check("total_cnt", 32'(total_cnt), m_total);
            check("req_ready", 32'(req_if.req_ready), 32'(q.size() == 0));
            if (!done) begin
                check("flush_nodone", 32'(flush), 0);
                check("link_we_nodone", 32'(link_we), 0);
            end
            if (q.size() > 0) begin
                e = q[0];
                check("redirect_valid", 32'(redirect_valid), 32'(e.kind == 1 && cyc != e.acc));
                check("exc_valid", 32'(exc_valid), 32'(e.kind == 2 && cyc != e.acc));
                if (redirect_valid) check("redirect_pc", redirect_pc, e.pc);
                if (exc_valid) begin
                    check("exc_cause", 32'(exc_cause), 32'(e.cause));
                    check("exc_tval", exc_tval, e.tval);
                end
                if (done) begin
                    obs = flush ? 1 : (exc_valid ? 2 : 0);
                    check("done_kind", obs, e.kind);
                    check("link_we", 32'(link_we), 32'(e.lwe));
                    if (e.lwe) check("link_data", link_data, e.ldata);
                    if (e.kind == 0) check("nt_latency", cyc, e.acc);
                    void'(q.pop_front());
                    if (m_total < CMAX) m_total++;
                    if (e.kind == 1 && m_taken < CMAX) m_taken++;
                end
            end else if (done) begin
                check("done_unexpected", 32'(done), 0);
            end
        end
    end

    task automatic issue(input logic [2:0] f, input bit jal, input bit jalr,
                         input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm,
                         input int unsigned h);
        exp_t e;
        int unsigned t = 0;
        bit acc = 0;
        e = model(f, jal, jalr, pc, rs1, rs2, imm);
        hold = h;
        req_if.req_valid   = 1'b1;
        req_if.req_func    = f;
        req_if.req_is_jal  = jal;
        req_if.req_is_jalr = jalr;
        req_if.req_pc      = pc;
        req_if.req_rs1     = rs1;
        req_if.req_rs2     = rs2;
        req_if.req_imm     = imm;
        while (!acc) begin
            @(negedge clk);
            if (req_if.req_ready) acc = 1;
            else if (++t > 200) begin
                check("accept_timeout", 32'(req_if.req_ready), 1);
                req_if.req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        e.acc = cyc;
        q.push_back(e);
        req_if.req_valid = 1'b0;
        // Scramble the bus so any unregistered use of it shows up.
        req_if.req_func = 3'($urandom);
        req_if.req_pc   = $urandom;
        req_if.req_rs1  = $urandom;
        req_if.req_rs2  = $urandom;
        req_if.req_imm  = $urandom;
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (q.size() != 0) check("idle_timeout", q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_if.req_ready), 1);
        check({tag, "_redirect_valid"}, 32'(redirect_valid), 0);
        check({tag, "_flush"}, 32'(flush), 0);
        check({tag, "_link_we"}, 32'(link_we), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_exc_valid"}, 32'(exc_valid), 0);
        check({tag, "_redirect_pc"}, redirect_pc, 0);
        check({tag, "_link_data"}, link_data, 0);
        check({tag, "_exc_cause"}, 32'(exc_cause), 0);
        check({tag, "_exc_tval"}, exc_tval, 0);
        check({tag, "_taken_cnt"}, 32'(taken_cnt), 0);
        check({tag, "_total_cnt"}, 32'(total_cnt), 0);
    endtask

    initial begin
        logic [31:0] imm;
        int unsigned r, t;
        req_if.req_valid = 1'b0;
        req_if.req_func = '0;
        req_if.req_is_jal = 1'b0;
        req_if.req_is_jalr = 1'b0;
        req_if.req_pc = '0;
        req_if.req_rs1 = '0;
        req_if.req_rs2 = '0;
        req_if.req_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed cases.
        issue(3'd0, 0, 0, 32'h100, 32'd5, 32'd5, 32'h20, 0);          // BEQ taken
        wait_idle();
        check("beq_taken_cnt", 32'(taken_cnt), 1);
        check("beq_total_cnt", 32'(total_cnt), 1);
        issue(3'd4, 0, 0, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1);  // BLT taken
        issue(3'd6, 0, 0, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 0);  // BLTU not taken
        issue(3'd0, 0, 1, 32'h400, 32'h1001, 32'd0, 32'd2, 3);        // JALR misaligned
        issue(3'd0, 1, 0, 32'h200, 32'd0, 32'd0, 32'h40, 4);          // JAL, fetch stalls
        issue(3'd2, 0, 0, 32'h500, 32'd1, 32'd1, 32'h8, 1);           // funct3 010
        issue(3'd0, 1, 1, 32'h600, 32'd1, 32'd1, 32'h8, 0);           // jal && jalr
        wait_idle();

        // Reset while a redirect is pending.
        issue(3'd0, 1, 0, 32'h700, 32'd0, 32'd0, 32'h80, 1000);
        t = 0;
        while (!redirect_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reach_redir", 32'(redirect_valid), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        m_taken = 0;
        m_total = 0;
        check_reset_outputs("midrst");
        hold = 0;
        rst = 1'b0;

        // Random traffic; also drives both counters into saturation.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) imm = $urandom;
            else imm = 32'($urandom_range(0, 127) * 4) - 32'd256;
            issue(3'($urandom), r == 0, r == 1 || r == 2 ? 1'b1 : 1'b0 | (r == 2),
                  $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3)),
                  $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3)),
                  imm, $urandom_range(0, 3));
        end
        wait_idle();
        @(negedge clk);
        check("total_sat", 32'(total_cnt), CMAX);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
